ps2_scan_decoder: RTL and testbench
===================================

Name: ps2_scan_decoder

Overview:
- Downstream of the PS/2 byte receiver. Consumes received scan-code bytes and strips the E0 (extended) and F0 (break) prefixes.
- Discards keyboard control bytes and emits one key event per completed sequence.
- Events are buffered in a small FIFO with a valid/ready output interface for the key-handling logic.
- Runs in the system clock domain. The caller synchronizes the receiver's output and supplies a one-cycle strobe per byte.

Parameters:
- DEPTH, 4, event FIFO depth; power of two, >= 2.
- TIMEOUT_CYC, 50000, clk cycles a partial prefix sequence may wait for its next byte before being abandoned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_byte  input  8  received scan-code byte; valid only when in_valid=1.
- in_valid  input  1  one-cycle strobe per received byte.
- out_ready  input  1  consumer accepts the head event this cycle.
- out_valid  output  1  FIFO non-empty.
- out_code  output  8  head event scan code.
- out_ext  output  1  head event was E0-prefixed.
- out_brk  output  1  head event is a key release (F0-prefixed).
- fifo_count  output  $clog2(DEPTH)+1  events held.
- ovf  output  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  input  1  clears ovf.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, FIFO empty, timeout counter=0.
  - out_valid=0, out_code=0x00, out_ext=0, out_brk=0, fifo_count=0, ovf=0.
- Control bytes: 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF. In any state, a control byte is discarded, state goes to IDLE, and no event is produced.
- Prefix bytes: E0, F0 (and E1, see Optional Feature).
- Data byte: any byte that is neither a control byte nor a prefix byte.
- States: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions happen only on in_valid=1 edges:
  - IDLE: E0->GOT_E0; F0->GOT_F0; data->emit{code,ext=0,brk=0}, stay IDLE.
  - GOT_E0: F0->GOT_E0F0; E0->GOT_E0; data->emit{code,1,0}->IDLE.
  - GOT_F0: data->emit{code,0,1}->IDLE; E0->GOT_E0; F0->GOT_F0.
  - GOT_E0F0: data->emit{code,1,1}->IDLE; E0->GOT_E0; F0->GOT_F0.
  - Rule summary: any prefix arriving out of order restarts decoding as if it arrived in IDLE, except GOT_E0 followed by F0.
- Timeout:
  - Counter increments each cycle while state!=IDLE and resets to 0 on every in_valid.
  - When it reaches TIMEOUT_CYC-1 with no byte, state goes to IDLE and no event is produced.
  - The counter holds 0 in IDLE.
- Emit: the event is written to the FIFO on the same edge that samples the completing byte.
  - out_valid rises in the following cycle (1-cycle latency from in_valid to out_valid when empty).
  - An empty FIFO emits nothing until written; there is no bypass path.
- FIFO:
  - Head fields (out_code/out_ext/out_brk) are stable while out_valid=1 and out_ready=0.
  - Pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle: count is unchanged and both succeed, including when full.
  - Push when full with no pop: the event is dropped and ovf is set.
  - Pointers wrap modulo DEPTH.
  - When empty, the out_* fields are don't-care to consumers but must not be X; they hold the last value.
- ovf:
  - Set on any drop; cleared by ovf_clr.
  - If a drop and ovf_clr occur in the same cycle, set wins.
- in_valid is never asserted on consecutive cycles by the upstream, but the block must accept back-to-back bytes.
- Reset mid-sequence discards the partial prefix and all buffered events.

Optional Feature:
- Macro: PS2_PAUSE_SEQ_EN.
- Defined:
  - Adds states P1..P7, which match the Pause sequence E1 14 77 E1 F0 14 F0 77.
  - E1 in any state goes to P1.
  - Each expected byte advances the match. On the final 77, one event {code=0x77, ext=1, brk=0} is emitted and state goes to IDLE. No break event is produced for Pause.
  - A mismatched byte goes to IDLE, and the byte is discarded; an E1 restarts at P1 instead.
  - Timeout and control-byte rules apply in P1..P7.
- Undefined:
  - E1 is treated as a discarded byte that forces IDLE.
  - The Pause sequence therefore yields events {14,0,0}, {77,0,0}, {14,0,1}, {77,0,1}.

Test Plan:
- Make/break: bytes 1C, F0 1C with out_ready=1 -> events {1C,0,0} then {1C,0,1}; out_valid high one cycle after each completing in_valid.
- Extended: E0 75, E0 F0 75 -> {75,1,0}, {75,1,1}; out-of-order F0 E0 6B -> {6B,1,0}.
- Control/timeout: E0, then AA -> no event, state IDLE. Separately, with TIMEOUT_CYC=16: F0 followed by a 20-cycle gap then 1C -> {1C,0,0}.
- Overflow: DEPTH=4, out_ready=0, send 5 data bytes -> fifo_count=4, ovf=1, head=1st byte. ovf_clr -> ovf=0. Drain -> bytes 1-4 in order.
- Full push+pop: FIFO full, a completing byte arrives in the same cycle as out_ready=1 -> count stays 4, ovf stays 0.
- Pause (macro defined): E1 14 77 E1 F0 14 F0 77 -> exactly one event {77,1,0}. With E1 14 33 -> no event, state IDLE. Reset asserted mid-sequence -> FIFO empty, out_valid=0.

Source files
------------

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: strips E0/F0 prefixes, drops control bytes, and queues key events.
// Pause-sequence decoding (E1 14 77 E1 F0 14 F0 77) is enabled by defining PS2_PAUSE_SEQ_EN.
module ps2_scan_decoder #(
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                in_byte,
   input  logic                      in_valid,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [7:0]                out_code,
   output logic                      out_ext,
   output logic                      out_brk,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      ovf,
   input  logic                      ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      GOT_E0   = 4'd1,
      GOT_F0   = 4'd2,
      GOT_E0F0 = 4'd3
`ifdef PS2_PAUSE_SEQ_EN
      ,
      P1       = 4'd4,
      P2       = 4'd5,
      P3       = 4'd6,
      P4       = 4'd7,
      P5       = 4'd8,
      P6       = 4'd9,
      P7       = 4'd10
`endif
   } state_t;

   function automatic logic is_ctrl(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
         default:                                  is_ctrl = 1'b0;
      endcase
   endfunction

`ifdef PS2_PAUSE_SEQ_EN
   function automatic logic is_pause(input state_t s);
      case (s)
         P1, P2, P3, P4, P5, P6, P7: is_pause = 1'b1;
         default:                    is_pause = 1'b0;
      endcase
   endfunction

   // Byte each Pause-match state is waiting for.
   function automatic logic [7:0] pause_expect(input state_t s);
      case (s)
         P1:      pause_expect = 8'h14;
         P2:      pause_expect = 8'h77;
         P3:      pause_expect = 8'hE1;
         P4:      pause_expect = 8'hF0;
         P5:      pause_expect = 8'h14;
         P6:      pause_expect = 8'hF0;
         P7:      pause_expect = 8'h77;
         default: pause_expect = 8'h00;
      endcase
   endfunction

   function automatic state_t pause_next(input state_t s);
      case (s)
         P1:      pause_next = P2;
         P2:      pause_next = P3;
         P3:      pause_next = P4;
         P4:      pause_next = P5;
         P5:      pause_next = P6;
         P6:      pause_next = P7;
         default: pause_next = IDLE;
      endcase
   endfunction
`endif

   state_t          state_r;
   state_t          next_state_s;
   logic [TW-1:0]   tmo_r;
   logic            push_s;
   logic            push_ext_s;
   logic            push_brk_s;
   logic [9:0]      event_s;

   logic [9:0]      mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [AW-1:0]   rd_next_s;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_next_s;
   logic            pop_s;
   logic            wr_en_s;
   logic            drop_s;
   logic [9:0]      head_next_s;
   logic            out_valid_r;
   logic [7:0]      out_code_r;
   logic            out_ext_r;
   logic            out_brk_r;
   logic            ovf_r;

   // Prefix decoder: next state and the event completed by the current byte.
   always_comb begin
      next_state_s = state_r;
      push_s       = 1'b0;
      push_ext_s   = 1'b0;
      push_brk_s   = 1'b0;
      if (in_valid) begin
         if (is_ctrl(in_byte)) begin
            next_state_s = IDLE;
`ifdef PS2_PAUSE_SEQ_EN
         end else if (is_pause(state_r)) begin
            if (in_byte == pause_expect(state_r)) begin
               if (state_r == P7) begin
                  next_state_s = IDLE;
                  push_s       = 1'b1;
                  push_ext_s   = 1'b1;
               end else begin
                  next_state_s = pause_next(state_r);
               end
            end else if (in_byte == 8'hE1) begin
               next_state_s = P1;
            end else begin
               next_state_s = IDLE;
            end
         end else if (in_byte == 8'hE1) begin
            next_state_s = P1;
`else
         end else if (in_byte == 8'hE1) begin
            next_state_s = IDLE;
`endif
         end else if (in_byte == 8'hE0) begin
            next_state_s = GOT_E0;
         end else if (in_byte == 8'hF0) begin
            next_state_s = (state_r == GOT_E0) ? GOT_E0F0 : GOT_F0;
         end else begin
            next_state_s = IDLE;
            push_s       = 1'b1;
            push_ext_s   = (state_r == GOT_E0) || (state_r == GOT_E0F0);
            push_brk_s   = (state_r == GOT_F0) || (state_r == GOT_E0F0);
         end
      end else if ((state_r != IDLE) && (tmo_r == TMO_LAST)) begin
         next_state_s = IDLE;
      end else begin
         next_state_s = state_r;
      end
   end

   // Decoder state and partial-sequence timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         tmo_r   <= {TW{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (in_valid || (next_state_s == IDLE)) begin
            tmo_r <= {TW{1'b0}};
         end else begin
            tmo_r <= tmo_r + TW'(1);
         end
      end
   end

   assign event_s = {in_byte, push_ext_s, push_brk_s};
   assign pop_s   = out_valid_r & out_ready;
   assign wr_en_s = push_s & ((count_r != FULL_CNT) | pop_s);
   assign drop_s  = push_s & (count_r == FULL_CNT) & ~pop_s;

   // Next occupancy, read pointer, and the entry that will sit at the head.
   always_comb begin
      case ({wr_en_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase
      rd_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
      if (wr_en_s && (wr_ptr_r == rd_next_s)) begin
         head_next_s = event_s;
      end else begin
         head_next_s = mem_r[rd_next_s];
      end
   end

   // Event storage and pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 10'd0;
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= event_s;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         rd_ptr_r <= rd_next_s;
         count_r  <= count_next_s;
      end
   end

   // Registered head view; fields hold their last value while the FIFO is empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_code_r  <= 8'h00;
         out_ext_r   <= 1'b0;
         out_brk_r   <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         out_valid_r <= (count_next_s != {CW{1'b0}});
         if (count_next_s != {CW{1'b0}}) begin
            out_code_r <= head_next_s[9:2];
            out_ext_r  <= head_next_s[1];
            out_brk_r  <= head_next_s[0];
         end
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end
      end
   end

   assign out_valid  = out_valid_r;
   assign out_code   = out_code_r;
   assign out_ext    = out_ext_r;
   assign out_brk    = out_brk_r;
   assign fifo_count = count_r;
   assign ovf        = ovf_r;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder (DEPTH=4, TIMEOUT_CYC=16); follows PS2_PAUSE_SEQ_EN.
module tb_ps2_scan_decoder;

   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_byte;
   logic       in_valid;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_code;
   logic       out_ext;
   logic       out_brk;
   logic [2:0] fifo_count;
   logic       ovf;
   logic       ovf_clr;

   int         checks = 0;
   int         errors = 0;
   logic [9:0] sb_q [$];

   always #5 clk = ~clk;

   ps2_scan_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_byte    (in_byte),
      .in_valid   (in_valid),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_code   (out_code),
      .out_ext    (out_ext),
      .out_brk    (out_brk),
      .fifo_count (fifo_count),
      .ovf        (ovf),
      .ovf_clr    (ovf_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Consumer side: every accepted head event is matched against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_event", 32'(sb_q.size()), 32'd1);
            end else begin
               check("sb_event", {22'd0, out_code, out_ext, out_brk}, {22'd0, sb_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic expect_evt(input logic [7:0] c, input logic e, input logic k);
      sb_q.push_back({c, e, k});
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      in_byte  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Completing byte into an empty FIFO: out_valid must rise right after the sampling edge.
   task automatic send_lat(input string tag, input logic [7:0] b, input logic e, input logic k);
      expect_evt(b, e, k);
      @(posedge clk); #1;
      in_byte  = b;
      in_valid = 1'b1;
      check({tag, "_pre"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_lat"}, 32'(out_valid), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((sb_q.size() != 0 || out_valid === 1'b1) && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      check(tag, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] pause_seq [8];
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      rst       = 1'b1;
      in_byte   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ovf_clr   = 1'b0;
      idle(3);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_code", 32'(out_code), 32'd0);
      check("rst_ext", 32'(out_ext), 32'd0);
      check("rst_brk", 32'(out_brk), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      idle(2);

      // Make / break
      send_lat("make", 8'h1C, 1'b0, 1'b0);
      send(8'hF0);
      send_lat("brk", 8'h1C, 1'b0, 1'b1);

      // Extended, and out-of-order prefixes
      send(8'hE0);
      send_lat("ext_make", 8'h75, 1'b1, 1'b0);
      send(8'hE0); send(8'hF0);
      send_lat("ext_brk", 8'h75, 1'b1, 1'b1);
      send(8'hF0); send(8'hE0);
      expect_evt(8'h6B, 1'b1, 1'b0);
      send(8'h6B);
      send(8'hF0); send(8'hF0);
      expect_evt(8'h29, 1'b0, 1'b1);
      send(8'h29);
      wait_drain("drain_ext");

      // Control bytes abandon the sequence
      send(8'hE0); send(8'hAA);
      idle(4);
      check("ctrl_no_event", 32'(out_valid), 32'd0);
      expect_evt(8'h1C, 1'b0, 1'b0);
      send(8'h1C);
      send(8'hE0); send(8'hF0); send(8'hFA);
      expect_evt(8'h2B, 1'b0, 1'b0);
      send(8'h2B);

      // Timeout: long gap abandons the prefix, short gap keeps it
      send(8'hF0);
      idle(20);
      expect_evt(8'h1C, 1'b0, 1'b0);
      send(8'h1C);
      send(8'hF0);
      idle(10);
      expect_evt(8'h1C, 1'b0, 1'b1);
      send(8'h1C);
      wait_drain("drain_ctrl_tmo");

      // Pause sequence
      for (int i = 0; i < 8; i++) begin
`ifdef PS2_PAUSE_SEQ_EN
         if (i == 7) expect_evt(8'h77, 1'b1, 1'b0);
`else
         if (i == 1) expect_evt(8'h14, 1'b0, 1'b0);
         if (i == 2) expect_evt(8'h77, 1'b0, 1'b0);
         if (i == 5) expect_evt(8'h14, 1'b0, 1'b1);
         if (i == 7) expect_evt(8'h77, 1'b0, 1'b1);
`endif
         send(pause_seq[i]);
      end
      wait_drain("drain_pause");
`ifdef PS2_PAUSE_SEQ_EN
      send(8'hE1); send(8'h14); send(8'h33);
      idle(3);
      check("pause_abort_none", 32'(out_valid), 32'd0);
`else
      expect_evt(8'h14, 1'b0, 1'b0);
      expect_evt(8'h33, 1'b0, 1'b0);
      send(8'hE1); send(8'h14); send(8'h33);
      idle(3);
`endif
      expect_evt(8'h1C, 1'b0, 1'b0);
      send(8'h1C);
      wait_drain("drain_pause_abort");

      // Overflow with consumer stalled
      out_ready = 1'b0;
      expect_evt(8'h15, 1'b0, 1'b0);
      expect_evt(8'h16, 1'b0, 1'b0);
      expect_evt(8'h1E, 1'b0, 1'b0);
      expect_evt(8'h26, 1'b0, 1'b0);
      send(8'h15); send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      check("ovf_count", 32'(fifo_count), 32'd4);
      check("ovf_set", 32'(ovf), 32'd1);
      check("ovf_head", 32'(out_code), 32'h15);
      check("ovf_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      in_byte  = 8'h36;
      in_valid = 1'b1;
      ovf_clr  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      ovf_clr  = 1'b0;
      check("ovf_set_wins", 32'(ovf), 32'd1);
      check("ovf_head_stable", 32'(out_code), 32'h15);
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(ovf), 32'd0);

      // Full FIFO: push and pop in the same cycle both succeed
      expect_evt(8'h2E, 1'b0, 1'b0);
      @(posedge clk); #1;
      in_byte   = 8'h2E;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("full_pp_count", 32'(fifo_count), 32'd4);
      check("full_pp_ovf", 32'(ovf), 32'd0);
      check("full_pp_head", 32'(out_code), 32'h16);
      out_ready = 1'b1;
      wait_drain("drain_ovf");
      check("drained_count", 32'(fifo_count), 32'd0);

      // Reset mid-sequence discards buffered events and the partial prefix
      out_ready = 1'b0;
      send(8'h1C);
      send(8'hE0);
      check("pre_rst_count", 32'(fifo_count), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_code", 32'(out_code), 32'd0);
      idle(2);
      rst       = 1'b0;
      out_ready = 1'b1;
      idle(1);
      send_lat("post_rst", 8'h75, 1'b0, 1'b0);
      wait_drain("drain_final");

      check("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
